// File: rtl/instruction_encoder_loader.sv
// Packs RV32I instruction fields into a word and streams it byte-wise (LE) into a boot memory port.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instruction_encoder_loader #(
    parameter int ADDR_W      = 12,
    parameter int BASE_ADDR   = 0,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] word_count,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, FULL} state_t;

    state_t      state, state_nx;
    logic [31:0] word, enc;
    logic [1:0]  byte_idx;
    logic        fmt_ok, range_ok, hs, accept, reject, last_word;

    always_comb begin
        enc    = 32'h0;
        fmt_ok = 1'b1;
        case (fmt)
            3'd0:    enc = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1:    enc = {imm[11:0], rs1, funct3, rd, opcode};
            3'd2:    enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            3'd3:    enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            3'd4:    enc = {imm[31:12], rd, opcode};
            3'd5:    enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: fmt_ok = 1'b0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Sign-extension checks: all bits above the field's sign bit must match it.
    always_comb begin
        range_ok = 1'b1;
        case (fmt)
            3'd1, 3'd2: range_ok = (imm[31:11] == {21{imm[11]}});
            3'd3:       range_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
            3'd4:       range_ok = (imm[11:0] == 12'h0);
            3'd5:       range_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
            default:    range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    assign hs        = in_valid && in_ready;
    assign accept    = hs && fmt_ok && range_ok;
    assign reject    = hs && !(fmt_ok && range_ok);
    assign last_word = ((32'(word_count) + 32'd1) == 32'(DEPTH_WORDS));

    // Outputs decode from state so an async reset drops mem_we immediately.
    assign in_ready  = (state == ACCEPT);
    assign mem_we    = (state == WRITE);
    assign done      = (state == FULL);
    assign mem_addr  = ADDR_W'(BASE_ADDR) + {word_count[ADDR_W-3:0], 2'b00} + ADDR_W'(byte_idx);
    assign mem_wdata = (state == WRITE) ? word[{byte_idx, 3'b000} +: 8] : 8'h00;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ACCEPT;
            ACCEPT:  if (accept) state_nx = WRITE;
            WRITE:   if (byte_idx == 2'd3) state_nx = last_word ? FULL : ACCEPT;
            FULL:    if (start) state_nx = ACCEPT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            word       <= 32'h0;
            byte_idx   <= 2'd0;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nx;
            if (start && state != WRITE) begin
                word_count <= '0;
                err        <= 1'b0;
            end
            if (reject) err <= 1'b1;
            if (accept) begin
                word     <= enc;
                byte_idx <= 2'd0;
            end
            if (state == WRITE) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) word_count <= word_count + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed bench for instruction_encoder_loader: queue-based byte-stream model plus literal word checks.
module tb_instruction_encoder_loader;
    localparam int ADDR_W = 12;
    localparam int BASE   = 0;
`ifdef ENC_RANGE_CHECK_EN
    localparam int DEPTH  = 6;
    localparam int S_AD   = 16;
`else
    localparam int DEPTH  = 7;
    localparam int S_AD   = 20;
`endif

    logic clk = 0, reset = 1, start = 0, in_valid = 0;
    logic [2:0] fmt = 0, funct3 = 0;
    logic [6:0] opcode = 0, funct7 = 0;
    logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
    logic [31:0] imm = 0;
    logic in_ready, mem_we, done, err;
    logic [ADDR_W-1:0] mem_addr, word_count;
    logic [7:0] mem_wdata;

    int total = 0, bad = 0;

    instruction_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .word_count(word_count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Reference encoding built from shifted/masked fields.
    function automatic logic [31:0] enc_model(input logic [2:0] f, input logic [6:0] op,
        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] lo, regs;
        lo   = 32'(op) | (32'(d) << 7);
        regs = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12);
        case (f)
            3'd0: return (32'(f7) << 25) | regs | lo;
            3'd1: return ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | lo;
            3'd2: return (((im >> 5) & 32'h7F) << 25) | regs | ((im & 32'h1F) << 7) | 32'(op);
            3'd3: return (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | regs
                       | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | 32'(op);
            3'd4: return (im & 32'hFFFFF000) | lo;
            default: return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                       | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | lo;
        endcase
    endfunction

    function automatic bit legal(input logic [2:0] f, input logic [31:0] im);
        if (f > 3'd5) return 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        case (f)
            3'd1, 3'd2: return $signed(im) >= -2048 && $signed(im) <= 2047;
            3'd3: return $signed(im) >= -4096 && $signed(im) <= 4095 && im[0] == 1'b0;
            3'd4: return im[11:0] == 12'h0;
            3'd5: return $signed(im) >= -1048576 && $signed(im) <= 1048575 && im[0] == 1'b0;
            default: return 1'b1;
        endcase
`else
        return 1'b1;
`endif
    endfunction

    // Model: pending byte writes as {addr, data}; words counted when the last byte drains.
    logic [ADDR_W+7:0] m_q[$];
    int m_cnt = 0;
    bit m_err = 0, m_full = 0, m_act = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_cnt = 0; m_err = 0; m_full = 0; m_act = 0;
        end else begin
            bit busy, rdy;
            logic [31:0] w;
            busy = m_q.size() != 0;
            rdy  = m_act && !busy && !m_full;
            if (busy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_cnt++;
                    if (m_cnt == DEPTH) m_full = 1;
                end
            end
            if (start && !busy) begin
                m_act = 1; m_full = 0; m_cnt = 0; m_err = 0;
            end
            if (in_valid && rdy) begin
                if (legal(fmt, imm)) begin
                    w = enc_model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
                    for (int i = 0; i < 4; i++)
                        m_q.push_back({ADDR_W'(BASE + 4 * m_cnt + i), 8'((w >> (8 * i)) & 32'hFF)});
                end else m_err = 1;
            end
        end
    end

    logic [7:0] mem_img [0:4095];

    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", in_ready, m_act && m_q.size() == 0 && !m_full);
            chk("mem_we", mem_we, m_q.size() != 0);
            chk("done", done, m_full);
            chk("err", err, m_err);
            chk("word_count", word_count, 32'(ADDR_W'(m_cnt)));
            if (mem_we && m_q.size() != 0) begin
                chk("mem_addr", mem_addr, m_q[0][ADDR_W+7:8]);
                chk("mem_wdata", mem_wdata, m_q[0][7:0]);
            end
            if (mem_we) mem_img[mem_addr] = mem_wdata;
        end
    end

    function automatic logic [31:0] word_at(input int a);
        return {mem_img[a+3], mem_img[a+2], mem_img[a+1], mem_img[a]};
    endfunction

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] im, output int waits);
        @(negedge clk);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1; waits = 0;
        while (!in_ready && waits < 60) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL handshake_timeout: in_ready never rose");
            in_valid = 0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    task automatic settle();
        repeat (5) @(posedge clk);
        #2;
    endtask

    initial begin
        int w;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_word_count", word_count, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        pulse_start();

        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, w);        // add x3,x1,x2
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, w);        // addi x1,x0,5
        chk("i_ready_low_cycles", w, 4);
        settle();
        chk("word_r", word_at(0), 32'h002081B3);
        chk("word_i", word_at(4), 32'h00500093);
        chk("count_2", word_count, 2);

        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFF8, w); // beq -8
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, w);     // jal x1,2048
        settle();
        chk("word_b", word_at(8), 32'hFE000CE3);
        chk("word_j", word_at(12), 32'h001000EF);

        send(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, w);        // illegal fmt
        chk("bad_fmt_err", err, 1);
        settle();
        chk("bad_fmt_count", word_count, 4);

        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, w);     // out-of-range imm
        settle();
`ifdef ENC_RANGE_CHECK_EN
        chk("range_err", err, 1);
        chk("range_count", word_count, 4);
`else
        chk("trunc_word", word_at(16), 32'h00000113);
        chk("trunc_count", word_count, 5);
`endif

        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12, w);       // sw x2,12(x1)
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, w); // lui x5
        settle();
        chk("word_s", word_at(S_AD), 32'h0020A623);
        chk("word_u", word_at(S_AD + 4), 32'h123452B7);
        chk("full_done", done, 1);
        chk("full_ready", in_ready, 0);
        chk("full_count", word_count, DEPTH);

        // Offer another bundle while full: it must not be taken.
        @(negedge clk);
        fmt = 3'd1; opcode = 7'h13; rd = 5'd7; rs1 = 5'd7; funct3 = 3'd0; imm = 32'hFFFFFFFF;
        in_valid = 1;
        repeat (10) @(negedge clk);
        in_valid = 0;
        chk("full_hold_count", word_count, DEPTH);

        pulse_start();
        chk("restart_done", done, 0);
        chk("restart_err", err, 0);
        send(3'd1, 7'h13, 5'd7, 5'd7, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, w); // addi x7,x7,-1
        settle();
        chk("restart_word", word_at(BASE), 32'hFFF38393);
        chk("restart_count", word_count, 1);

        // Reset after byte 1 of a word.
        send(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0, w);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1;
        #1;
        chk("abort_mem_we", mem_we, 0);
        chk("abort_count", word_count, 0);
        chk("abort_ready", in_ready, 0);
        @(negedge clk);
        #2 reset = 0;
        @(negedge clk);
        in_valid = 1;
        repeat (8) @(negedge clk);
        in_valid = 0;
        chk("idle_count", word_count, 0);
        chk("idle_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
